alu_op_sequencer: RTL and testbench

- Control and result stage of the ALU.
- Latches operands and opcode on a start request, then drives the registered operands to the combinational units (and_32b, or_32b, xor/nor, adder/subtractor).
- Captures the selected unit's result, or runs the 32-cycle shift-add multiplier for MULT, and presents a registered result with a done pulse.
- It is the stage directly upstream (operand feed) and downstream (result capture) of the bitwise units.

---
 rtl/alu_pkg.sv | 16 +
 rtl/mul_seq_32b.sv | 31 +++
 rtl/alu_op_sequencer.sv | 107 ++++++++++
 tb/tb_alu_op_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state encodings and width default for the ALU control stage
package alu_pkg;
   localparam int WIDTH = 32;
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NOR  = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_MULT = 3'b111;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_MUL  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/mul_seq_32b.sv
// mul_seq_32b: unsigned shift-add multiplier datapath, one iteration per step, last once all WIDTH iterations are done
module mul_seq_32b #(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               last,
   output logic [2*WIDTH-1:0] prod
);
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   sum;
   assign sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, a};
   assign last = cnt == CNT_W'(WIDTH);
   always_ff @(posedge clk) begin
      if (reset) begin
         prod <= '0;
         cnt  <= '0;
      end else if (load) begin
         prod <= {{WIDTH{1'b0}}, b};
         cnt  <= '0;
      end else if (step) begin
         prod <= prod[0] ? {sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
         cnt  <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: ALU operand latch, result mux/capture and MULT sequencing; ALU_FLAGS_EN adds zero/ovf/carry outputs
module alu_op_sequencer import alu_pkg::*; #(
   parameter int WIDTH = alu_pkg::WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] a_q,
   output logic [WIDTH-1:0] b_q,
   input  logic [WIDTH-1:0] and_res,
   input  logic [WIDTH-1:0] or_res,
   input  logic [WIDTH-1:0] xor_res,
   input  logic [WIDTH-1:0] nor_res,
   input  logic [WIDTH-1:0] add_res,
   input  logic [WIDTH-1:0] sub_res,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi
`ifdef ALU_FLAGS_EN
   ,
   output logic             zero,
   output logic             ovf,
   output logic             carry
`endif
);
   logic [1:0]         state, state_n;
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   exec_res;
   logic [2*WIDTH-1:0] prod;
   logic               accept, mul_last, sub_ovf;
   assign accept  = state == S_IDLE && start;
   assign busy    = state != S_IDLE;
   assign done    = state == S_DONE;
   assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (sub_res[WIDTH-1] != a_q[WIDTH-1]);
   always_comb begin
      exec_res = op_q == OP_AND ? and_res :
                 op_q == OP_OR  ? or_res  :
                 op_q == OP_XOR ? xor_res :
                 op_q == OP_NOR ? nor_res :
                 op_q == OP_ADD ? add_res :
                 op_q == OP_SUB ? sub_res :
                 op_q == OP_SLT ? {{(WIDTH-1){1'b0}}, sub_res[WIDTH-1] ^ sub_ovf} : '0;
      state_n  = state == S_IDLE ? (start ? (op == OP_MULT ? S_MUL : S_EXEC) : S_IDLE) :
                 state == S_EXEC ? S_DONE :
                 state == S_MUL  ? (mul_last ? S_DONE : S_MUL) : S_IDLE;
   end
   // b_in is loaded into the product register on the same edge that latches it into b_q
   mul_seq_32b #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
      .clk  (clk),
      .reset(reset),
      .load (accept && op == OP_MULT),
      .step (state == S_MUL && !mul_last),
      .a    (a_q),
      .b    (b_in),
      .last (mul_last),
      .prod (prod)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         result_lo <= '0;
         result_hi <= '0;
      end else begin
         if (accept) begin
            a_q  <= a_in;
            b_q  <= b_in;
            op_q <= op;
         end
         if (state == S_EXEC) begin
            result_lo <= exec_res;
            result_hi <= '0;
         end
         if (state == S_MUL && mul_last) begin
            result_lo <= prod[WIDTH-1:0];
            result_hi <= prod[2*WIDTH-1:WIDTH];
         end
         state <= state_n;
      end
   end
`ifdef ALU_FLAGS_EN
   logic add_ovf;
   assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (add_res[WIDTH-1] != a_q[WIDTH-1]);
   always_ff @(posedge clk) begin
      if (reset) begin
         zero  <= 1'b0;
         ovf   <= 1'b0;
         carry <= 1'b0;
      end else if (state == S_EXEC) begin
         zero  <= exec_res == '0;
         ovf   <= op_q == OP_ADD ? add_ovf : op_q == OP_SUB ? sub_ovf : 1'b0;
         carry <= 1'b0;
      end else if (state == S_MUL && mul_last) begin
         zero  <= prod == '0;
         ovf   <= 1'b0;
         carry <= prod[2*WIDTH-1:WIDTH] != '0;
      end
   end
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench for alu_op_sequencer with modelled bitwise/arithmetic units
module tb_alu_op_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] a_in = '0, b_in = '0;
   logic [31:0] a_q, b_q, result_lo, result_hi;
   logic [31:0] and_res, or_res, xor_res, nor_res, add_res, sub_res;
   logic        busy, done;
`ifdef ALU_FLAGS_EN
   logic        zero, ovf, carry;
`endif
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   assign and_res = a_q & b_q;
   assign or_res  = a_q | b_q;
   assign xor_res = a_q ^ b_q;
   assign nor_res = ~(a_q | b_q);
   assign add_res = a_q + b_q;
   assign sub_res = a_q - b_q;

   alu_op_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a_in     (a_in),
      .b_in     (b_in),
      .a_q      (a_q),
      .b_q      (b_q),
      .and_res  (and_res),
      .or_res   (or_res),
      .xor_res  (xor_res),
      .nor_res  (nor_res),
      .add_res  (add_res),
      .sub_res  (sub_res),
      .busy     (busy),
      .done     (done),
      .result_lo(result_lo),
      .result_hi(result_hi)
`ifdef ALU_FLAGS_EN
      ,
      .zero     (zero),
      .ovf      (ovf),
      .carry    (carry)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Issues one op, optionally pokes a start at cycle inj while busy, and checks latency, busy span and results.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi, input int elat, input int inj);
      int cyc, nbusy, ndone;
      @(posedge clk); #1;
      start = 1'b1; op = o; a_in = a; b_in = b;
      @(posedge clk); #1;
      start = 1'b0; op = 3'b000; a_in = '0; b_in = '0;
      cyc = 1;
      nbusy = 0;
      while (!done && cyc < 100) begin
         if (busy) nbusy++;
         if (cyc == inj) begin
            start = 1'b1; op = 3'b000; a_in = '1; b_in = '1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      check({tag, " latency"}, 64'(cyc), 64'(elat));
      check({tag, " busy cycles"}, 64'(nbusy), 64'(elat - 1));
      check({tag, " busy at done"}, 64'(busy), 64'd1);
      check({tag, " lo"}, 64'(result_lo), 64'(elo));
      check({tag, " hi"}, 64'(result_hi), 64'(ehi));
      ndone = 0;
      repeat (3) begin
         @(posedge clk); #1;
         ndone += int'(done);
      end
      check({tag, " extra done"}, 64'(ndone), 64'd0);
      check({tag, " idle busy"}, 64'(busy), 64'd0);
      check({tag, " lo held"}, 64'(result_lo), 64'(elo));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset lo", 64'(result_lo), 64'd0);
      check("reset hi", 64'(result_hi), 64'd0);
      check("reset a_q", 64'(a_q), 64'd0);
      reset = 1'b0;

      run_op("or",    3'b001, 32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF, 32'h0, 2, 0);
      run_op("and",   3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 32'h0, 2, 0);
      run_op("xor",   3'b010, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 32'h0, 2, 0);
      run_op("nor",   3'b011, 32'hF0F0_0000, 32'h0F0F_00FF, 32'h0000_FF00, 32'h0, 2, 0);
      run_op("add",   3'b100, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h0, 2, 0);
      run_op("sub",   3'b101, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0, 2, 0);
      run_op("slt1",  3'b110, 32'h8000_0000, 32'h0000_0001, 32'h1, 32'h0, 2, 0);
      run_op("slt2",  3'b110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 2, 0);
      run_op("slt3",  3'b110, 32'h0000_0005, 32'h0000_0007, 32'h1, 32'h0, 2, 0);
      run_op("slt4",  3'b110, 32'h0000_0007, 32'h0000_0007, 32'h0, 32'h0, 2, 0);
      run_op("mulmax", 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 34, 0);
`ifdef ALU_FLAGS_EN
      check("mul carry", 64'(carry), 64'd1);
      check("mul zero", 64'(zero), 64'd0);
`endif
      run_op("mulbusy", 3'b111, 32'd3, 32'd5, 32'd15, 32'h0, 34, 10);
      run_op("mulsh", 3'b111, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'h1, 34, 0);
      run_op("mulz",  3'b111, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 34, 0);
`ifdef ALU_FLAGS_EN
      check("mulz zero", 64'(zero), 64'd1);
      check("mulz carry", 64'(carry), 64'd0);
`endif

      run_op("pre", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 2, 0);
      @(posedge clk); #1;
      start = 1'b1; op = 3'b111; a_in = 32'd7; b_in = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      check("mid-mul busy", 64'(busy), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst lo", 64'(result_lo), 64'd0);
      check("rst hi", 64'(result_hi), 64'd0);
      check("rst a_q", 64'(a_q), 64'd0);
      check("rst b_q", 64'(b_q), 64'd0);
      run_op("add after rst", 3'b100, 32'd2, 32'd3, 32'd5, 32'h0, 2, 0);

`ifdef ALU_FLAGS_EN
      run_op("addovf", 3'b100, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0, 2, 0);
      check("addovf ovf", 64'(ovf), 64'd1);
      check("addovf zero", 64'(zero), 64'd0);
      run_op("sub0", 3'b101, 32'd5, 32'd5, 32'h0, 32'h0, 2, 0);
      check("sub0 zero", 64'(zero), 64'd1);
      check("sub0 ovf", 64'(ovf), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
